// File: rtl/sample_sched_pkg.sv
// Shared definitions for the sample scheduler.
//   CH_NUM_MAX : largest supported channel count
//   ch_w(n)    : channel index width for n channels, at least 1 bit
package sample_sched_pkg;

  localparam int CH_NUM_MAX = 16;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_sched_rr_arbiter.sv
// Combinational round-robin priority rotate.
// Picks the first requesting index at or after ptr, wrapping modulo N.
//   req       : request vector, one bit per channel
//   ptr       : starting index for the search (must be < N)
//   en        : qualifies the grant; no grant when low
//   gnt_idx   : granted index (0 when gnt_valid is low)
//   gnt_valid : a grant was made
module rr_arbiter
  import sample_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = ch_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          en,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_valid
);

  function automatic logic [CW-1:0] rot(input logic [CW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return CW'(s);
  endfunction

  // Walk offsets from far to near so the nearest requester wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en && req[rot(ptr, i)]) begin
        gnt_idx   = rot(ptr, i);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_sched.sv
// Round-robin sample scheduler: one tagged input stream updates per-channel
// sample-and-hold registers; a single registered output stream emits the
// newest value of each eligible channel in round-robin order.
//   clk, rst            : clock, synchronous active-high reset
//   din_data            : {ch, value}, ch in the CH_W MSBs
//   din_valid/din_ready : input handshake, ready is always 1
//   dout_data           : {ch, value}, fully registered
//   dout_valid/ready    : output handshake
module sample_sched
  import sample_sched_pkg::*;
#(
  parameter int            CH_NUM     = 4,
  parameter int            W          = 8,
  parameter bit            HOLD       = 1'b1,
  parameter logic [W-1:0]  INIT       = '0,
  parameter bit            INIT_VALID = 1'b0,
  parameter int            CW         = ch_w(CH_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW+W-1:0] din_data,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [CW+W-1:0] dout_data,
  output logic            dout_valid,
  input  logic            dout_ready
);

  logic [W-1:0]      val [CH_NUM];
  logic [CH_NUM-1:0] vld;
  logic [CH_NUM-1:0] fresh;
  logic [CW-1:0]     ptr;

  logic [CW-1:0]     din_ch;
  logic [W-1:0]      din_val;
  logic              din_hit;
  logic [CH_NUM-1:0] din_onehot;
  logic [CH_NUM-1:0] req;
  logic              out_free;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic [W-1:0]      gnt_val;

  assign din_ready = 1'b1;
  assign din_ch    = din_data[CW+W-1:W];
  assign din_val   = din_data[W-1:0];
  assign din_hit   = din_valid && (int'(din_ch) < CH_NUM);

  always_comb begin
    din_onehot = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (din_hit && din_ch == CW'(i)) din_onehot[i] = 1'b1;
    end
  end

  // The incoming beat's channel is eligible in the same cycle so a write to
  // an idle scheduler reaches dout one cycle later.
  assign req      = (HOLD ? fresh : vld) | din_onehot;
  assign out_free = !dout_valid || dout_ready;

  rr_arbiter #(.N(CH_NUM), .CW(CW)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .en        (out_free),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Bypass: a simultaneous write to the granted channel is what goes out.
  assign gnt_val = (din_hit && din_ch == gnt_idx) ? din_val : val[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) val[i] <= INIT;
      vld        <= {CH_NUM{INIT_VALID}};
      fresh      <= {CH_NUM{INIT_VALID}};
      ptr        <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
    end else begin
      if (din_hit) begin
        val[din_ch]   <= din_val;
        vld[din_ch]   <= 1'b1;
        fresh[din_ch] <= 1'b1;
      end
      if (out_free) begin
        if (gnt_valid) begin
          dout_data  <= {gnt_idx, gnt_val};
          dout_valid <= 1'b1;
          // Placed after the write so a bypassed channel ends up not fresh.
          fresh[gnt_idx] <= 1'b0;
          ptr <= (gnt_idx == CW'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_sched.sv
module tb_sample_sched;
  import sample_sched_pkg::*;

  localparam int CH_NUM = 4;
  localparam int W      = 8;
  localparam int CW     = 2;
  localparam int DW     = CW + W;
  localparam int NCFG   = 3;  // 0: HOLD=1, 1: HOLD=0, 2: HOLD=1 INIT_VALID=1

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din_data;
  logic          din_valid;
  logic          dout_ready;

  logic          rdy0, rdy1, rdy2;
  logic [DW-1:0] dd0, dd1, dd2;
  logic          dv0, dv1, dv2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample_sched #(.CH_NUM(CH_NUM), .W(W), .HOLD(1'b1), .INIT(8'h00), .INIT_VALID(1'b0)) u_dut_hold (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(rdy0),
    .dout_data(dd0), .dout_valid(dv0), .dout_ready(dout_ready));

  sample_sched #(.CH_NUM(CH_NUM), .W(W), .HOLD(1'b0), .INIT(8'h00), .INIT_VALID(1'b0)) u_dut_nohold (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(rdy1),
    .dout_data(dd1), .dout_valid(dv1), .dout_ready(dout_ready));

  sample_sched #(.CH_NUM(CH_NUM), .W(W), .HOLD(1'b1), .INIT(8'h00), .INIT_VALID(1'b1)) u_dut_initv (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(rdy2),
    .dout_data(dd2), .dout_valid(dv2), .dout_ready(dout_ready));

  // ---------------- reference model ----------------
  int m_val   [NCFG][CH_NUM];
  bit m_vld   [NCFG][CH_NUM];
  bit m_fresh [NCFG][CH_NUM];
  int m_ptr   [NCFG];
  bit m_ov    [NCFG];
  int m_och   [NCFG];
  int m_oval  [NCFG];

  function automatic bit cfg_hold(input int k);
    return k != 1;
  endfunction

  function automatic bit cfg_initv(input int k);
    return k == 2;
  endfunction

  function automatic logic [DW+1:0] obs(input int k);
    case (k)
      0:       return {rdy0, dv0, dd0};
      1:       return {rdy1, dv1, dd1};
      default: return {rdy2, dv2, dd2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_ov[k]  = 1'b0;
      m_ptr[k] = 0;
      for (int c = 0; c < CH_NUM; c++) begin
        m_val[k][c]   = 0;
        m_vld[k][c]   = cfg_initv(k);
        m_fresh[k][c] = cfg_initv(k);
      end
    end
  endtask

  // One clock of behaviour: pick the first eligible channel scanning from
  // the pointer, then apply the write, then emit the (now newest) value.
  task automatic model_step(input bit wr, input int ch, input int v, input bit rdy);
    for (int k = 0; k < NCFG; k++) begin
      bit freeo;
      int g;
      freeo = !m_ov[k] || rdy;
      g = -1;
      if (freeo) begin
        for (int off = 0; off < CH_NUM; off++) begin
          int c;
          bit el;
          c  = (m_ptr[k] + off) % CH_NUM;
          el = (cfg_hold(k) ? m_fresh[k][c] : m_vld[k][c]) || (wr && ch == c);
          if (el && g < 0) g = c;
        end
      end
      if (wr && ch < CH_NUM) begin
        m_val[k][ch]   = v;
        m_vld[k][ch]   = 1'b1;
        m_fresh[k][ch] = 1'b1;
      end
      if (freeo) begin
        if (g >= 0) begin
          m_ov[k]       = 1'b1;
          m_och[k]      = g;
          m_oval[k]     = m_val[k][g];
          m_fresh[k][g] = 1'b0;
          m_ptr[k]      = (g + 1) % CH_NUM;
        end else begin
          m_ov[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NCFG; k++) begin
      logic [DW+1:0] o;
      o = obs(k);
      check($sformatf("din_ready[cfg%0d]", k), 32'(o[DW+1]), 32'd1);
      check($sformatf("dout_valid[cfg%0d]", k), 32'(o[DW]), 32'(m_ov[k]));
      if (m_ov[k])
        check($sformatf("dout_data[cfg%0d]", k), 32'(o[DW-1:0]),
              32'((m_och[k] << W) | m_oval[k]));
    end
  endtask

  // At a negedge: check outputs, drive inputs for the next edge, advance.
  task automatic cyc(input bit wr, input int ch, input int v, input bit rdy);
    compare_all();
    din_valid  = wr;
    din_data   = {CW'(ch), W'(v)};
    dout_ready = rdy;
    model_step(wr, ch, v, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] beat(input logic v, input int ch, input int val);
    logic [DW:0] b;
    b = {v, CW'(ch), W'(val)};
    return 32'(b);
  endfunction

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    do_reset();
    check("reset_valid_hold", 32'(dv0), 32'd0);
    check("reset_valid_initv", 32'(dv2), 32'd0);

    // Write to idle scheduler: one-cycle latency, then idle.
    cyc(1, 2, 8'h5A, 1);
    check("latency_beat", beat(dv0, int'(dd0[DW-1:W]), int'(dd0[W-1:0])), beat(1'b1, 2, 8'h5A));
    cyc(0, 0, 0, 1);
    check("idle_after_single", 32'(dv0), 32'd0);
    cyc(0, 0, 0, 1);
    check("idle_after_single2", 32'(dv0), 32'd0);

    // Stall, collapse repeated writes.
    cyc(1, 0, 8'h01, 0);
    cyc(1, 1, 8'h10, 0);
    cyc(1, 1, 8'h11, 0);
    cyc(1, 1, 8'h12, 0);
    check("stall_hold", {dv0, dd0}, beat(1'b1, 0, 8'h01));
    cyc(0, 0, 0, 1);
    check("collapse_newest", {dv0, dd0}, beat(1'b1, 1, 8'h12));
    cyc(0, 0, 0, 1);
    check("collapse_no_old", 32'(dv0), 32'd0);

    // Pointer to 3 via ch2, then all fresh in one stall window.
    cyc(1, 2, 8'h20, 1);
    cyc(1, 0, 8'hA0, 0);
    cyc(1, 1, 8'hA1, 0);
    cyc(1, 2, 8'hA2, 0);
    cyc(1, 3, 8'hA3, 0);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (3 + i) % 4;
      cyc(0, 0, 0, 1);
      check($sformatf("rr_order_%0d", i), {dv0, dd0}, beat(1'b1, c, 8'hA0 + c));
    end
    cyc(0, 0, 0, 1);

    // Bypass on the granted channel.
    cyc(1, 0, 8'h01, 0);
    cyc(1, 1, 8'h66, 0);
    cyc(1, 1, 8'h77, 1);
    check("bypass_value", {dv0, dd0}, beat(1'b1, 1, 8'h77));
    cyc(0, 0, 0, 1);
    check("bypass_not_fresh", 32'(dv0), 32'd0);

    // HOLD=0: two channels alternate indefinitely.
    do_reset();
    cyc(1, 0, 8'hAA, 1);
    cyc(1, 3, 8'hBB, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("nohold_alt_%0d", i), {dv1, dd1},
            (i % 2 == 0) ? beat(1'b1, 3, 8'hBB) : beat(1'b1, 0, 8'hAA));
      cyc(0, 0, 0, 1);
    end

    // INIT_VALID: drain, stall a beat, reset mid-stall, drain again.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      check($sformatf("initv_first_%0d", i), {dv2, dd2}, beat(1'b1, i, 0));
    end
    cyc(0, 0, 0, 1);
    cyc(1, 2, 8'h33, 0);
    cyc(0, 0, 0, 0);
    check("initv_stalled", {dv2, dd2}, beat(1'b1, 2, 8'h33));
    do_reset();
    check("initv_reset_drop", 32'(dv2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      check($sformatf("initv_after_rst_%0d", i), {dv2, dd2}, beat(1'b1, i, 0));
    end
    cyc(0, 0, 0, 1);
    check("initv_idle", 32'(dv2), 32'd0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        compare_all();
        do_reset();
      end else begin
        cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, CH_NUM - 1)),
            int'($urandom_range(0, 255)), $urandom_range(0, 9) < 7);
      end
    end
    compare_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_sched.md
# sample_sched

Round-robin sample scheduler that shares one `dout` stream between `CH_NUM` sample channels. Each channel keeps its latest value in an internal sample-and-hold register, written from a single tagged `din` stream that is always accepted. The scheduler grants `dout` to eligible channels in round-robin order. It sits behind multiplexed sensor/status sources whose consumers want only the newest value per channel, never a backlog.

## Interface

Parameters:
- `CH_NUM`, 4: number of channels, 2..16.
- `HOLD`, 1: 1 means a channel is emitted only when its value is fresh (written since its last emission). 0 means every channel that has ever been valid is re-emitted each round.
- `INIT`, 0: reset value of every channel register.
- `INIT_VALID`, 0: 1 means all channels are valid and fresh after reset, holding `INIT`.

Ports:
- `clk`, input, 1: clock. One clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `din`, dti.consumer, CH_W+W: `{ch, value}`. `ch` occupies the CH_W MSBs. CH_W = $clog2(CH_NUM). W is the remaining width.
- `dout`, dti.producer, CH_W+W: `{ch, value}`, same format as `din`.

## Operation

- `din.ready` is tied to 1. A `din` beat with `ch >= CH_NUM` is dropped.
- A `din.valid` beat writes `val[ch] <= value` and sets `vld[ch] <= 1` and `fresh[ch] <= 1`.
- Eligible set:
  - `HOLD=1`: `fresh[i]`, plus the channel of the current `din` beat.
  - `HOLD=0`: `vld[i]`, plus the channel of the current `din` beat.
- The output register is free when `!dout.valid`, or when the current cycle has a handshake (`dout.valid && dout.ready`).
- When the output register is free and the eligible set is non-empty:
  - Grant the first eligible channel at or after `ptr`, modulo CH_NUM.
  - Load `{g, val[g]}` into the output register and set `dout.valid`.
  - Clear `fresh[g]` and set `ptr <= g+1` modulo CH_NUM.
- When the output register is free and nothing is eligible, `dout.valid` drops to 0.
- Simultaneous `din` write to the granted channel: the output carries the incoming value (bypass), and `fresh[g]` ends up 0.
- `din` write to the channel currently held stalled in `dout`: `dout` is unchanged, and `fresh` is set so the channel is rescheduled later.
- Repeated writes to a channel before it is granted collapse. Only the newest value is emitted.
- `dout.data` and `dout.valid` must not change while `dout.valid && !dout.ready`.
- Reset values:
  - `dout.valid = 0`, `ptr = 0`.
  - `val[i] = INIT`, `vld[i] = INIT_VALID`, `fresh[i] = INIT_VALID`.
- Reset mid-operation drops any pending `dout` beat and all freshness state.

## Timing

- Latency: a `din` beat at cycle t, with the output register free, gives `dout.valid` at t+1 carrying that beat.
- Throughput: one `dout` beat per cycle under `dout.ready=1` when at least one channel is eligible.
- `dout` is fully registered. There is no combinational path from `din` or `dout.ready` to `dout.data` or `dout.valid`.
- The grant decision uses `dout.ready` combinationally: the next beat loads in the handshake cycle itself, with no bubble.
- Fairness: with k channels continuously eligible, each channel is granted exactly once per k consecutive handshakes.

## Structure

- `sample_sched` holds the channel register bank, the bypass logic and the output register.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt_idx`, `gnt_valid`.
  - Purely combinational priority rotate. `ptr` update stays in the parent.
- Shared package `sample_sched_pkg`:
  - Function `ch_w(n)` returning `$clog2(n)`, with a minimum of 1.
  - Constant `CH_NUM_MAX = 16`.

## Test plan

Setup for all scenarios: CH_NUM=4, W=8, HOLD=1, INIT_VALID=0 unless stated.

- Reset then hold `dout.ready=1`. Write `{2,0x5A}` at cycle t. Required: `dout={2,0x5A}` valid at t+1, and `dout.valid=0` from t+2 onward.
- Hold `dout.ready=0` with `dout={0,0x01}` stalled. Write ch1 0x10, then 0x11, then 0x12. Required: `dout` stays `{0,0x01}` while stalled. After `ready=1`, the next beat is `{1,0x12}`; 0x10 and 0x11 never appear.
- Force `ptr=3` by granting ch2 first. Then make ch0..ch3 all fresh in one stall window and release `ready`. Required order: ch3, ch0, ch1, ch2, one per cycle, no bubbles.
- HOLD=0. Write ch0=0xAA and ch3=0xBB once, with `ready=1`. Required: `dout` alternates `{0,0xAA}`, `{3,0xBB}` indefinitely.
- In the cycle ch1 is granted, also write ch1=0x77 (older value 0x66). Required: `dout={1,0x77}`, and ch1 is not re-emitted afterwards.
- INIT_VALID=1, INIT=0. Assert `rst` for 1 cycle while `{2,0x33}` is stalled. Required: `dout.valid=0` in the cycle after reset. After reset, `{0,0},{1,0},{2,0},{3,0}` are emitted in that order, then `dout` goes idle.
